// File: rtl/id_ex.sv
// ID/EX pipeline register with a one-entry skid buffer.
// ready_o comes straight from state bits, so it has no combinational path from ready_i.
module id_ex #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        flush_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [31:0] op1_jump_i,
  input  logic [31:0] op2_jump_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] reg1_rdata_i,
  input  logic [31:0] reg2_rdata_i,
  input  logic [31:0] csr_rdata_i,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        csr_we_i,
  input  logic [31:0] csr_waddr_i,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [31:0] op1_jump_o,
  output logic [31:0] op2_jump_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic [31:0] reg1_rdata_o,
  output logic [31:0] reg2_rdata_o,
  output logic [31:0] csr_rdata_o,
  output logic [31:0] csr_waddr_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic        csr_we_o,
  output logic        valid_o,
  input  logic        ready_i
);

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] op1_jump;
    logic [31:0] op2_jump;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic [31:0] reg1_rdata;
    logic [31:0] reg2_rdata;
    logic [31:0] csr_rdata;
    logic [31:0] csr_waddr;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic        csr_we;
  } payload_t;

  // bit0 = OUT valid, bit1 = SKID valid
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t   state_q, state_d;
  payload_t out_q, out_d;
  payload_t skid_q, skid_d;
  payload_t in_s;
  logic     accept_s;
  logic     consume_s;

  // OUT is reloaded with this whenever it empties, so the idle outputs come from a flop
  function automatic payload_t idle_payload();
    payload_t p;
    p      = '0;
    p.inst = NOP_INST;
    return p;
  endfunction

  assign in_s = '{op1: op1_i, op2: op2_i, op1_jump: op1_jump_i, op2_jump: op2_jump_i,
                  inst: inst_i, inst_addr: inst_addr_i, reg1_rdata: reg1_rdata_i,
                  reg2_rdata: reg2_rdata_i, csr_rdata: csr_rdata_i, csr_waddr: csr_waddr_i,
                  reg_we: reg_we_i, reg_waddr: reg_waddr_i, csr_we: csr_we_i};

  assign valid_o   = state_q[0];
  assign ready_o   = ~state_q[1];
  assign accept_s  = valid_i & ready_o;
  assign consume_s = valid_o & ready_i;

  // Next-state and next-payload selection
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      out_d   = idle_payload();
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_s) begin
            state_d = ONE;
            out_d   = in_s;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          case ({accept_s, consume_s})
            2'b11: out_d = in_s;
            2'b10: begin
              state_d = FULL;
              skid_d  = in_s;
            end
            2'b01: begin
              state_d = EMPTY;
              out_d   = idle_payload();
            end
            default: state_d = ONE;
          endcase
        end
        FULL: begin
          if (consume_s) begin
            state_d = ONE;
            out_d   = skid_q;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
          out_d   = idle_payload();
        end
      endcase
    end
  end

  // State and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= idle_payload();
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign op1_o        = out_q.op1;
  assign op2_o        = out_q.op2;
  assign op1_jump_o   = out_q.op1_jump;
  assign op2_jump_o   = out_q.op2_jump;
  assign inst_o       = out_q.inst;
  assign inst_addr_o  = out_q.inst_addr;
  assign reg1_rdata_o = out_q.reg1_rdata;
  assign reg2_rdata_o = out_q.reg2_rdata;
  assign csr_rdata_o  = out_q.csr_rdata;
  assign csr_waddr_o  = out_q.csr_waddr;
  assign reg_we_o     = out_q.reg_we;
  assign reg_waddr_o  = out_q.reg_waddr;
  assign csr_we_o     = out_q.csr_we;

endmodule

// File: tb/tb_id_ex.sv
// Self-checking bench for id_ex: directed scenarios, then random valid/ready traffic
// checked against a queue model of in-order buffering with capacity two.
module tb_id_ex;

  localparam int W = 327;
  localparam int INST_LSB = 167;
  localparam int WADDR_LSB = 1;
  localparam int WE_BIT = 6;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_i = 1'b0;
  logic ready_i = 1'b0;
  logic flush_i = 1'b0;
  logic ready_o, valid_o;
  logic [W-1:0] in_vec = '0;
  logic [W-1:0] out_vec;

  logic [31:0] op1_i, op2_i, op1_jump_i, op2_jump_i, inst_i, inst_addr_i;
  logic [31:0] reg1_rdata_i, reg2_rdata_i, csr_rdata_i, csr_waddr_i;
  logic        reg_we_i, csr_we_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] op1_o, op2_o, op1_jump_o, op2_jump_o, inst_o, inst_addr_o;
  logic [31:0] reg1_rdata_o, reg2_rdata_o, csr_rdata_o, csr_waddr_o;
  logic        reg_we_o, csr_we_o;
  logic [4:0]  reg_waddr_o;

  assign {op1_i, op2_i, op1_jump_i, op2_jump_i, inst_i, inst_addr_i, reg1_rdata_i,
          reg2_rdata_i, csr_rdata_i, csr_waddr_i, reg_we_i, reg_waddr_i, csr_we_i} = in_vec;
  assign out_vec = {op1_o, op2_o, op1_jump_o, op2_jump_o, inst_o, inst_addr_o, reg1_rdata_o,
                    reg2_rdata_o, csr_rdata_o, csr_waddr_o, reg_we_o, reg_waddr_o, csr_we_o};

  id_ex dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
    .op1_i(op1_i), .op2_i(op2_i), .op1_jump_i(op1_jump_i), .op2_jump_i(op2_jump_i),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .reg1_rdata_i(reg1_rdata_i),
    .reg2_rdata_i(reg2_rdata_i), .csr_rdata_i(csr_rdata_i), .reg_we_i(reg_we_i),
    .reg_waddr_i(reg_waddr_i), .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i),
    .op1_o(op1_o), .op2_o(op2_o), .op1_jump_o(op1_jump_o), .op2_jump_o(op2_jump_o),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .reg1_rdata_o(reg1_rdata_o),
    .reg2_rdata_o(reg2_rdata_o), .csr_rdata_o(csr_rdata_o), .csr_waddr_o(csr_waddr_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .csr_we_o(csr_we_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int n_delivered = 0;
  logic [W-1:0] mq[$];

  function automatic logic [W-1:0] idle_vec();
    logic [W-1:0] v;
    v = '0;
    v[INST_LSB +: 32] = NOP;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [351:0] v;
    for (int i = 0; i < 11; i++) v[i*32 +: 32] = $urandom;
    return v[W-1:0];
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk_bit({tag, "_valid_o"}, valid_o, mq.size() > 0);
    chk_bit({tag, "_ready_o"}, ready_o, mq.size() < 2);
    chk_vec({tag, "_payload"}, out_vec, (mq.size() > 0) ? mq[0] : idle_vec());
  endtask

  // One clock with the currently driven inputs; the model follows the spec rules directly.
  task automatic step(input string tag);
    bit acc, cons;
    acc  = valid_i && (mq.size() < 2);
    cons = (mq.size() > 0) && ready_i;
    ready_i = ~ready_i;
    #1;
    chk_bit({tag, "_ready_indep"}, ready_o, mq.size() < 2);
    ready_i = ~ready_i;
    if (rst || flush_i) begin
      mq.delete();
    end else begin
      if (cons) begin
        void'(mq.pop_front());
        n_delivered++;
      end
      if (acc) mq.push_back(in_vec);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  logic [W-1:0] v;

  initial begin
    // Reset, then idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    chk_bit("reset_valid_o", valid_o, 1'b0);
    chk_bit("reset_ready_o", ready_o, 1'b1);
    chk_vec("reset_payload", out_vec, idle_vec());
    step("idle");

    // Single instruction, one-cycle latency
    ready_i = 1'b1;
    v = rand_vec();
    v[INST_LSB +: 32] = 32'h00500093;
    v[WADDR_LSB +: 5] = 5'd1;
    v[WE_BIT] = 1'b1;
    in_vec = v;
    valid_i = 1'b1;
    step("single_in");
    chk_vec("single_inst", {295'd0, inst_o}, {295'd0, 32'h00500093});
    valid_i = 1'b0;
    step("single_out");

    // Fill to FULL while stalled, then drain A then B
    ready_i = 1'b0;
    v = rand_vec(); v[INST_LSB +: 32] = 32'h00100093; in_vec = v; valid_i = 1'b1;
    step("stall_a");
    v = rand_vec(); v[INST_LSB +: 32] = 32'h00200113; in_vec = v;
    step("stall_b");
    chk_bit("full_ready_low", ready_o, 1'b0);
    valid_i = 1'b0;
    step("stall_hold1");
    step("stall_hold2");
    ready_i = 1'b1;
    chk_vec("drain_a_inst", {295'd0, inst_o}, {295'd0, 32'h00100093});
    step("drain_a");
    chk_vec("drain_b_inst", {295'd0, inst_o}, {295'd0, 32'h00200113});
    step("drain_b");

    // Flush while FULL with a simultaneous accept
    ready_i = 1'b0; valid_i = 1'b1;
    in_vec = rand_vec(); step("fl_fill1");
    in_vec = rand_vec(); step("fl_fill2");
    flush_i = 1'b1; in_vec = rand_vec();
    step("flush");
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    repeat (3) step("post_flush");

    // Reset mid-stall
    ready_i = 1'b0; valid_i = 1'b1;
    in_vec = rand_vec(); step("rs_fill1");
    in_vec = rand_vec(); step("rs_fill2");
    rst = 1'b1; in_vec = rand_vec();
    step("reset_full");
    rst = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    repeat (3) step("post_reset");

    // Random traffic without flush
    for (int c = 0; c < 10000; c++) begin
      valid_i = 1'($urandom_range(0, 1));
      ready_i = 1'($urandom_range(0, 1));
      in_vec  = rand_vec();
      step("rand");
    end
    valid_i = 1'b0; ready_i = 1'b1;
    repeat (3) step("rand_drain");
    chk_bit("rand_progress", n_delivered > 1000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
